// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared constants, FSM state type and helpers for the execute stage
// Package ex_pkg: ALU operation codes, branch codes carried on pc_in,
// mul/div FSM state enum and a 16-bit magnitude helper.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_SLL  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_SRA  = 4'h6;
    localparam logic [3:0] ALU_ROL  = 4'h7;
    localparam logic [3:0] ALU_ROR  = 4'h8;
    localparam logic [3:0] ALU_MUL  = 4'h9;
    localparam logic [3:0] ALU_DIV  = 4'hA;
    localparam logic [3:0] ALU_PASSB = 4'hB;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BLT  = 2'b10;
    localparam logic [1:0] BR_BGT  = 2'b11;

    localparam int MD_STEPS = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

    // Two's-complement magnitude; 0x8000 maps to 0x8000, which is correct
    // when the result is treated as unsigned.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? 16'(-v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX input bundle and EX/MEM output bundle of the execute stage
// master: upstream pipeline / forwarding sources (drives ID/EX and MEM/WB inputs)
// slave : ex_stage (drives the EX/MEM register outputs and stall)
interface ex_stage_if;
    logic [15:0] shift_in;
    logic [15:0] add_in;
    logic [15:0] read_data_in1;
    logic [15:0] read_data_in2;
    logic [3:0]  read_reg_in1;
    logic [3:0]  read_reg_in2;
    logic [3:0]  alu_func_in;
    logic [2:0]  ex_in;
    logic [1:0]  pc_in;
    logic [2:0]  m_in;
    logic [1:0]  wb_in;
    logic [15:0] memwb_data;
    logic [3:0]  memwb_reg;
    logic        memwb_we;
    logic [15:0] alu_out;
    logic [15:0] hi_out;
    logic [15:0] store_data_out;
    logic [3:0]  dest_reg_out;
    logic [2:0]  m_out;
    logic [1:0]  wb_out;
    logic        br_taken_out;
    logic [15:0] br_target_out;
    logic        div_zero_out;
    logic        stall;

    modport master (
        output shift_in, add_in, read_data_in1, read_data_in2, read_reg_in1, read_reg_in2,
               alu_func_in, ex_in, pc_in, m_in, wb_in, memwb_data, memwb_reg, memwb_we,
        input  alu_out, hi_out, store_data_out, dest_reg_out, m_out, wb_out,
               br_taken_out, br_target_out, div_zero_out, stall
    );

    modport slave (
        input  shift_in, add_in, read_data_in1, read_data_in2, read_reg_in1, read_reg_in2,
               alu_func_in, ex_in, pc_in, m_in, wb_in, memwb_data, memwb_reg, memwb_we,
        output alu_out, hi_out, store_data_out, dest_reg_out, m_out, wb_out,
               br_taken_out, br_target_out, div_zero_out, stall
    );
endinterface

// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - iterative signed 16x16 multiplier and restoring divider
// muldiv_unit: start/done handshake; 16 iterations on operand magnitudes, sign fixed at the end.
// Ports: clk, rst (async, active-high), start, isDiv, opA, opB in;
//        busy (combinational stall), done (DONE state), divZero, resLo, resHi out.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        isDiv,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic        divZero,
    output logic [15:0] resLo,
    output logic [15:0] resHi
);

    mdState_t    state;
    logic [3:0]  count;
    logic [31:0] work;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [15:0] mag;       // |B|: multiplicand or divisor
    logic [15:0] dividend;
    logic        opDiv, aNeg, bNeg, divByZero;

    logic [16:0] mulSum, remSh, diff;
    logic [31:0] mulStep, divStep, prod;

    assign mulSum  = {1'b0, work[31:16]} + (work[0] ? {1'b0, mag} : 17'd0);
    assign mulStep = {mulSum, work[15:1]};
    assign remSh   = {work[31:16], work[15]};
    assign diff    = remSh - {1'b0, mag};
    assign divStep = diff[16] ? {remSh[15:0], work[14:0], 1'b0}
                              : {diff[15:0],  work[14:0], 1'b1};
    assign prod    = (aNeg ^ bNeg) ? 32'(-work) : work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            work      <= '0;
            mag       <= '0;
            dividend  <= '0;
            opDiv     <= 1'b0;
            aNeg      <= 1'b0;
            bNeg      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opDiv     <= isDiv;
                    aNeg      <= opA[15];
                    bNeg      <= opB[15];
                    dividend  <= opA;
                    divByZero <= isDiv && (opB == 16'd0);
                    mag       <= abs16(opB);
                    work      <= {16'd0, abs16(opA)};
                    count     <= '0;
                    state     <= BUSY;
                end
                BUSY: begin
                    work  <= opDiv ? divStep : mulStep;
                    count <= count + 4'd1;
                    if (count == 4'(MD_STEPS - 1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates stall immediately, even while a mul/div code is still presented.
    assign busy    = !rst && ((state == IDLE && start) || state == BUSY);
    assign done    = (state == DONE);
    assign divZero = divByZero;

    always_comb begin
        resLo = prod[15:0];
        resHi = prod[31:16];
        if (opDiv) begin
            if (divByZero) begin
                resLo = 16'hFFFF;
                resHi = dividend;
            end else begin
                resLo = (aNeg ^ bNeg) ? 16'(-work[15:0]) : work[15:0];
                resHi = aNeg ? 16'(-work[31:16]) : work[31:16];
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, branch resolve, EX/MEM register
// Ports: clk, rst (async, active-high); bus (ex_stage_if.slave) carrying the ID/EX
// inputs, the MEM/WB forwarding source, the EX/MEM outputs and the upstream stall.
// Build option: EX_MULDIV_EN enables MUL/DIV through muldiv_unit; otherwise codes
// 9/A produce 0 and stall/div_zero_out stay 0.
module ex_stage
    import ex_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic [15:0] fwdA, fwdB, opB, aluRes;
    logic [31:0] rolW, rorW;
    logic        brCond;
    logic        mdDone, mdDivZero;
    logic [15:0] mdLo, mdHi;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    always_comb begin
        fwdA = bus.read_data_in1;
        if (bus.wb_out[1] && bus.dest_reg_out == bus.read_reg_in1)
            fwdA = bus.alu_out;
        else if (bus.memwb_we && bus.memwb_reg == bus.read_reg_in1)
            fwdA = bus.memwb_data;

        fwdB = bus.read_data_in2;
        if (bus.wb_out[1] && bus.dest_reg_out == bus.read_reg_in2)
            fwdB = bus.alu_out;
        else if (bus.memwb_we && bus.memwb_reg == bus.read_reg_in2)
            fwdB = bus.memwb_data;
    end

    assign opB  = bus.ex_in[0] ? bus.shift_in : fwdB;
    assign rolW = {fwdA, fwdA} << opB[3:0];
    assign rorW = {fwdA, fwdA} >> opB[3:0];

    always_comb begin
        aluRes = '0;
        case (bus.alu_func_in)
            ALU_ADD:   aluRes = fwdA + opB;
            ALU_SUB:   aluRes = fwdA - opB;
            ALU_AND:   aluRes = fwdA & opB;
            ALU_OR:    aluRes = fwdA | opB;
            ALU_SLL:   aluRes = fwdA << opB[3:0];
            ALU_SRL:   aluRes = fwdA >> opB[3:0];
            ALU_SRA:   aluRes = $signed(fwdA) >>> opB[3:0];
            ALU_ROL:   aluRes = rolW[31:16];
            ALU_ROR:   aluRes = rorW[15:0];
            ALU_PASSB: aluRes = opB;
            default:   aluRes = '0;
        endcase
    end

    // Branches always compare register operands, never the immediate.
    always_comb begin
        brCond = 1'b0;
        case (bus.pc_in)
            BR_NONE: brCond = 1'b0;
            BR_BEQ:  brCond = (fwdA == fwdB);
            BR_BLT:  brCond = ($signed(fwdA) < $signed(fwdB));
            BR_BGT:  brCond = ($signed(fwdA) > $signed(fwdB));
            default: brCond = 1'b0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic mdBusy;

    muldiv_unit u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.alu_func_in == ALU_MUL || bus.alu_func_in == ALU_DIV),
        .isDiv   (bus.alu_func_in == ALU_DIV),
        .opA     (fwdA),
        .opB     (opB),
        .busy    (mdBusy),
        .done    (mdDone),
        .divZero (mdDivZero),
        .resLo   (mdLo),
        .resHi   (mdHi)
    );

    assign bus.stall = mdBusy;
`else
    assign mdDone    = 1'b0;
    assign mdDivZero = 1'b0;
    assign mdLo      = '0;
    assign mdHi      = '0;
    assign bus.stall = 1'b0;
`endif

    // EX/MEM register. A stall inserts a bubble in the control fields and
    // leaves the data fields untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_out        <= '0;
            bus.hi_out         <= '0;
            bus.store_data_out <= '0;
            bus.dest_reg_out   <= '0;
            bus.m_out          <= '0;
            bus.wb_out         <= '0;
            bus.br_taken_out   <= 1'b0;
            bus.br_target_out  <= '0;
            bus.div_zero_out   <= 1'b0;
        end else if (bus.stall) begin
            bus.m_out        <= '0;
            bus.wb_out       <= '0;
            bus.br_taken_out <= 1'b0;
        end else begin
            bus.alu_out        <= mdDone ? mdLo : aluRes;
            bus.hi_out         <= mdDone ? mdHi : 16'd0;
            bus.div_zero_out   <= mdDone & mdDivZero;
            bus.store_data_out <= fwdB;
            bus.dest_reg_out   <= bus.read_reg_in1;
            bus.m_out          <= bus.m_in;
            bus.wb_out         <= bus.wb_in;
            bus.br_taken_out   <= brCond;
            bus.br_target_out  <= bus.add_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage (directed plan cases plus random ops)
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [3:0] func; logic [15:0] a, b, imm, addIn; logic [3:0] r1, r2;
        logic [2:0] exIn, m; logic [1:0] pc, wb; logic mwWe; logic [3:0] mwReg; logic [15:0] mwData;
    } op_t;

    typedef struct {
        string tag; logic [15:0] alu, hi, store, tgt; logic [3:0] dest; logic [2:0] m;
        logic [1:0] wb; logic br, dz; int stallCyc;
    } exp_t;

    exp_t        sbQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [15:0] prevAlu = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mkOp(input logic [3:0] func, input logic [15:0] a, b,
                                 input logic [3:0] r1, r2, input logic [1:0] wb,
                                 input logic [2:0] m, input logic [1:0] pc,
                                 input logic [2:0] exIn, input logic [15:0] imm, addIn);
        op_t o;
        o.func = func; o.a = a; o.b = b; o.r1 = r1; o.r2 = r2; o.wb = wb; o.m = m;
        o.pc = pc; o.exIn = exIn; o.imm = imm; o.addIn = addIn;
        o.mwWe = 1'b0; o.mwReg = 4'd0; o.mwData = 16'd0;
        return o;
    endfunction

    // Reference model, given the forwarded operand values the bench expects.
    function automatic exp_t model(input string tag, input op_t o, input logic [15:0] fa, fb);
        exp_t e; logic [15:0] ob; int sa, sb, q, r; logic [31:0] p;
        ob = o.exIn[0] ? o.imm : fb;
        sa = $signed(fa); sb = $signed(ob);
        e.tag = tag; e.alu = 16'd0; e.hi = 16'd0; e.dz = 1'b0; e.stallCyc = 0;
        case (o.func)
            4'h0: e.alu = fa + ob;
            4'h1: e.alu = fa - ob;
            4'h2: e.alu = fa & ob;
            4'h3: e.alu = fa | ob;
            4'h4: e.alu = fa << ob[3:0];
            4'h5: e.alu = fa >> ob[3:0];
            4'h6: e.alu = $signed(fa) >>> ob[3:0];
            4'h7: e.alu = (fa << ob[3:0]) | (fa >> (5'd16 - {1'b0, ob[3:0]}));
            4'h8: e.alu = (fa >> ob[3:0]) | (fa << (5'd16 - {1'b0, ob[3:0]}));
`ifdef EX_MULDIV_EN
            4'h9: begin
                p = 32'(sa * sb);
                e.alu = p[15:0]; e.hi = p[31:16]; e.stallCyc = 17;
            end
            4'hA: begin
                e.stallCyc = 17;
                if (ob == 16'd0) begin
                    e.alu = 16'hFFFF; e.hi = fa; e.dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.alu = q[15:0]; e.hi = r[15:0];
                end
            end
`endif
            4'hB: e.alu = ob;
            default: e.alu = 16'd0;
        endcase
        case (o.pc)
            2'b01:   e.br = (fa == fb);
            2'b10:   e.br = ($signed(fa) < $signed(fb));
            2'b11:   e.br = ($signed(fa) > $signed(fb));
            default: e.br = 1'b0;
        endcase
        e.store = fb; e.tgt = o.addIn; e.dest = o.r1; e.m = o.m; e.wb = o.wb;
        return e;
    endfunction

    task automatic drive(input op_t o);
        bus.alu_func_in = o.func;   bus.read_data_in1 = o.a;   bus.read_data_in2 = o.b;
        bus.read_reg_in1 = o.r1;    bus.read_reg_in2 = o.r2;   bus.shift_in = o.imm;
        bus.add_in = o.addIn;       bus.ex_in = o.exIn;        bus.pc_in = o.pc;
        bus.m_in = o.m;             bus.wb_in = o.wb;          bus.memwb_we = o.mwWe;
        bus.memwb_reg = o.mwReg;    bus.memwb_data = o.mwData;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_alu"}, bus.alu_out, 0);
        check({tag, "_hi"}, bus.hi_out, 0);
        check({tag, "_store"}, bus.store_data_out, 0);
        check({tag, "_dest"}, bus.dest_reg_out, 0);
        check({tag, "_m"}, bus.m_out, 0);
        check({tag, "_wb"}, bus.wb_out, 0);
        check({tag, "_br"}, bus.br_taken_out, 0);
        check({tag, "_tgt"}, bus.br_target_out, 0);
        check({tag, "_dz"}, bus.div_zero_out, 0);
        check({tag, "_stall"}, bus.stall, 0);
    endtask

    // Called just after a rising edge: drives the op, waits for the stall to drop,
    // then compares the EX/MEM contents one edge later against the scoreboard.
    task automatic doOp(input op_t o, input exp_t e);
        int   stallCnt;
        bit   seenLow;
        exp_t got;
        drive(o);
        sbQ.push_back(e);
        stallCnt = 0; seenLow = 1'b0;
        for (int i = 0; i < 40 && !seenLow; i++) begin
            @(negedge clk);
            if (bus.stall) begin
                stallCnt++;
                if (stallCnt == 2) begin
                    check({e.tag, "_bubble_wb"}, bus.wb_out, 0);
                    check({e.tag, "_bubble_m"}, bus.m_out, 0);
                    check({e.tag, "_bubble_hold"}, bus.alu_out, prevAlu);
                end
            end else begin
                seenLow = 1'b1;
            end
        end
        if (!seenLow) check({e.tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        got = sbQ.pop_front();
        check({got.tag, "_alu"}, bus.alu_out, got.alu);
        check({got.tag, "_hi"}, bus.hi_out, got.hi);
        check({got.tag, "_store"}, bus.store_data_out, got.store);
        check({got.tag, "_dest"}, bus.dest_reg_out, got.dest);
        check({got.tag, "_m"}, bus.m_out, got.m);
        check({got.tag, "_wb"}, bus.wb_out, got.wb);
        check({got.tag, "_br"}, bus.br_taken_out, got.br);
        check({got.tag, "_tgt"}, bus.br_target_out, got.tgt);
        check({got.tag, "_dz"}, bus.div_zero_out, got.dz);
        check({got.tag, "_stallcyc"}, stallCnt, got.stallCyc);
        prevAlu = got.alu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
        $fatal(1);
    end

    initial begin
        op_t  o;
        exp_t e;
        rst = 1'b1;
        drive(mkOp(4'hC, 0, 0, 0, 0, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0));
        @(posedge clk); #1;
        checkZero("por");
        rst = 1'b0;

        o = mkOp(ALU_ADD, 16'h7FFF, 16'h0001, 4'd1, 4'd2, 2'b10, 3'b101, BR_NONE, 3'b000, 0, 0);
        e = model("add_ovf", o, o.a, o.b); e.alu = 16'h8000; e.wb = 2'b10; doOp(o, e);

        o = mkOp(ALU_ADD, 16'd5, 16'd7, 4'd3, 4'd2, 2'b10, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("dep_add", o, o.a, o.b); e.alu = 16'd12; doOp(o, e);

        o = mkOp(ALU_SUB, 16'd5, 16'd5, 4'd3, 4'd5, 2'b10, 3'b010, BR_NONE, 3'b000, 0, 0);
        o.mwWe = 1'b1; o.mwReg = 4'd3; o.mwData = 16'h1234;
        e = model("fwd_exmem", o, 16'd12, 16'd5); e.alu = 16'd7; doOp(o, e);

        o = mkOp(ALU_OR, 16'h00F0, 16'h1111, 4'd6, 4'd7, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        o.mwWe = 1'b1; o.mwReg = 4'd7; o.mwData = 16'h000F;
        e = model("fwd_memwb", o, 16'h00F0, 16'h000F); e.alu = 16'h00FF; e.store = 16'h000F; doOp(o, e);

        o = mkOp(ALU_ADD, 16'hFFFF, 16'h0001, 4'd8, 4'd9, 2'b00, 3'b000, BR_BLT, 3'b000, 0, 16'h0040);
        e = model("blt", o, o.a, o.b); e.br = 1'b1; e.tgt = 16'h0040; doOp(o, e);

        o = mkOp(ALU_ADD, 16'hFFFF, 16'h0001, 4'd8, 4'd9, 2'b00, 3'b000, BR_BGT, 3'b000, 0, 16'h0080);
        e = model("bgt", o, o.a, o.b); e.br = 1'b0; doOp(o, e);

        o = mkOp(ALU_ADD, 16'h1234, 16'h1234, 4'd8, 4'd9, 2'b00, 3'b000, BR_BEQ, 3'b001, 16'h0000, 16'h0100);
        e = model("beq_imm", o, o.a, o.b); e.br = 1'b1; e.alu = 16'h1234; doOp(o, e);

        o = mkOp(ALU_SLL, 16'h0011, 16'h0000, 4'd8, 4'd9, 2'b00, 3'b000, BR_NONE, 3'b001, 16'd4, 0);
        e = model("sll_imm", o, o.a, o.b); e.alu = 16'h0110; doOp(o, e);

        o = mkOp(ALU_ROL, 16'h8001, 16'h0001, 4'd8, 4'd9, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("rol", o, o.a, o.b); e.alu = 16'h0003; doOp(o, e);

        o = mkOp(ALU_SRA, 16'h8000, 16'h0000, 4'd8, 4'd9, 2'b00, 3'b000, BR_NONE, 3'b001, 16'd15, 0);
        e = model("sra", o, o.a, o.b); e.alu = 16'hFFFF; doOp(o, e);

        o = mkOp(ALU_ROR, 16'h0001, 16'h0001, 4'd12, 4'd9, 2'b10, 3'b011, BR_NONE, 3'b000, 0, 0);
        e = model("ror", o, o.a, o.b); e.alu = 16'h8000; doOp(o, e);

        o = mkOp(ALU_MUL, 16'hFFFE, 16'h0003, 4'd13, 4'd14, 2'b10, 3'b001, BR_NONE, 3'b000, 0, 0);
        e = model("mul_neg", o, o.a, o.b);
`ifdef EX_MULDIV_EN
        e.alu = 16'hFFFA; e.hi = 16'hFFFF; e.stallCyc = 17;
`else
        e.alu = 16'h0000; e.hi = 16'h0000; e.stallCyc = 0;
`endif
        doOp(o, e);

        o = mkOp(ALU_DIV, 16'hFFF9, 16'h0002, 4'd15, 4'd0, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("div_neg", o, o.a, o.b);
`ifdef EX_MULDIV_EN
        e.alu = 16'hFFFD; e.hi = 16'hFFFF;
`endif
        doOp(o, e);

        o = mkOp(ALU_DIV, 16'h0010, 16'h0000, 4'd4, 4'd5, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("div_zero", o, o.a, o.b);
`ifdef EX_MULDIV_EN
        e.alu = 16'hFFFF; e.hi = 16'h0010; e.dz = 1'b1;
`endif
        doOp(o, e);

        o = mkOp(ALU_PASSB, 16'h0000, 16'hBEEF, 4'd6, 4'd7, 2'b11, 3'b110, BR_NONE, 3'b000, 0, 0);
        e = model("passb", o, o.a, o.b); e.alu = 16'hBEEF; e.dz = 1'b0; doOp(o, e);

        o = mkOp(4'hE, 16'h5555, 16'h3333, 4'd8, 4'd9, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("undef_e", o, o.a, o.b); e.alu = 16'h0000; doOp(o, e);

        // Reset in the middle of a multiply: outputs clear before any edge.
        drive(mkOp(ALU_MUL, 16'h0003, 16'h0005, 4'd8, 4'd9, 2'b10, 3'b111, BR_NONE, 3'b000, 0, 0));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkZero("rst_mid");
        @(posedge clk); #1;
        drive(mkOp(4'hC, 0, 0, 0, 0, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0));
        rst = 1'b0;

        o = mkOp(ALU_MUL, 16'h0003, 16'h0005, 4'd8, 4'd9, 2'b00, 3'b000, BR_NONE, 3'b000, 0, 0);
        e = model("mul_after_rst", o, o.a, o.b);
`ifdef EX_MULDIV_EN
        e.alu = 16'd15; e.hi = 16'd0;
`endif
        doOp(o, e);

        // Random ops; wb_in[1] kept low so the register-file operands are never forwarded.
        for (int i = 0; i < 24; i++) begin
            o = mkOp(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                     4'($urandom), 4'($urandom), {1'b0, 1'($urandom)}, 3'($urandom),
                     2'($urandom), {2'b00, 1'($urandom)}, 16'($urandom), 16'($urandom));
            if (i % 6 == 0) o.b = 16'd0;
            e = model($sformatf("rnd%0d_f%0h", i, o.func), o, o.a, o.b);
            doOp(o, e);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipelined processor. It consumes the ID/EX pipeline register outputs, resolves operand forwarding, and computes ALU results, branch decisions and multi-cycle multiply/divide results. It registers everything into the EX/MEM pipeline register held inside this block. While a multiply or divide is in flight it stalls the upstream stages.

## Interface
Parameters:
- none; all widths are fixed by the ISA (16-bit data, 16 registers).

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- shift_in  in  16  sign-extended immediate from ID/EX
- add_in  in  16  branch target from ID/EX
- read_data_in1 / read_data_in2  in  16  register-file operands A / B
- read_reg_in1 / read_reg_in2  in  4  source register numbers; read_reg_in1 is also the destination
- alu_func_in  in  4  operation code
- ex_in  in  3  [0] alu_src_imm (B = shift_in); [2:1] reserved, ignored
- pc_in  in  2  00 none, 01 BEQ, 10 BLT, 11 BGT
- m_in  in  3  memory-stage controls, passed through
- wb_in  in  2  [1] reg_write, [0] mem_to_reg, passed through
- memwb_data / memwb_reg / memwb_we  in  16/4/1  MEM/WB forwarding source
- alu_out, hi_out, store_data_out  out  16  EX/MEM result, high product or remainder, store data
- dest_reg_out  out  4;  m_out  out  3;  wb_out  out  2
- br_taken_out  out  1;  br_target_out  out  16
- div_zero_out  out  1  registered with a divide result
- stall  out  1  combinational; freezes PC, IF/ID and ID/EX

## Operation
- Forwarding, applied per operand: if EX/MEM wb_out[1] is set and dest_reg_out equals the source register, use alu_out. Otherwise, if memwb_we is set and memwb_reg equals the source register, use memwb_data. Otherwise use the register-file value. R0 gets no special treatment.
- Operand B is shift_in when ex_in[0]=1, otherwise forwarded B. store_data_out always takes forwarded B.
- ALU codes:
  - 0 ADD, 1 SUB: wrap mod 2^16.
  - 2 AND, 3 OR.
  - 4 SLL, 5 SRL, 6 SRA, 7 ROL, 8 ROR: shift amount is B[3:0].
  - 9 MUL: signed 16x16 to 32 bits; low half to alu_out, high half to hi_out.
  - A DIV: signed; quotient to alu_out, remainder to hi_out, remainder takes the sign of the dividend.
  - B PASS_B.
  - C–F: result 0.
  - hi_out is 0 for all non-mul/div operations.
- Branch: compare forwarded A against forwarded B; BLT and BGT are signed. br_taken_out=1 when the condition holds. br_target_out=add_in.
- Mul/div FSM:
  - IDLE: a MUL or DIV code drives stall=1; at the edge, operands latch, count=0, state goes to BUSY.
  - BUSY: 16 iterations, stall=1. At count==15 the next state is DONE.
  - DONE: stall=0; EX/MEM captures the result; state returns to IDLE.
- Divide by zero: quotient 0xFFFF, remainder = dividend, div_zero_out=1 for that result only.
- Bubble: whenever stall=1, EX/MEM captures m_out=0, wb_out=0, br_taken_out=0. Data fields hold their previous values.

## Timing
- Reset: all outputs 0, stall=0, FSM to IDLE. Reset mid-operation aborts the mul/div and discards partial results.
- Single-cycle operations: inputs present in cycle T; result on the outputs in T+1.
- Mul/div presented in T0: stall is high T0..T16, low in T17; EX/MEM captures at the end of T17; result visible in T18. Total 18-cycle latency.
- ID/EX inputs are held stable by the upstream stall. The FSM uses only the latched operands after T0.
- Back-to-back mul/div: the second op is first seen in T18 and starts from IDLE; there is no idle gap beyond DONE.
- Forwarding during DONE uses the latched operands; a forwarded value is never re-sampled.

## Configuration
- EX_MULDIV_EN defined: the multi-cycle FSM and sub-module are built as specified.
- EX_MULDIV_EN undefined: codes 9 and A are treated as undefined (result 0, hi_out 0); stall is tied to 0; div_zero_out is tied to 0.

## Structure
- Package ex_pkg holds the ALU code constants, the pc branch-code constants, and the FSM state enum (IDLE, BUSY, DONE).
- Sub-module muldiv_unit contains the shift-add multiplier, the restoring divider, the counter and the FSM. It has a start/done handshake and is instantiated only under EX_MULDIV_EN.

## Test plan
- Reset asserted mid-stream -> all outputs 0 and stall=0 in the same cycle, without waiting for a clock edge.
- ADD with A=0x7FFF, B=0x0001 -> alu_out=0x8000 one cycle later; wb_out passes through.
- Back-to-back dependency: ADD R3=R1+R2 followed by SUB R4=R3-R1, with R1=5 and R2=7 -> second op uses 12 forwarded from EX/MEM; alu_out=7. Also check that EX/MEM takes priority over a conflicting MEM/WB match.
- MUL with A=0xFFFE (-2), B=0x0003 -> stall high for exactly 17 cycles; in T18 alu_out=0xFFFA and hi_out=0xFFFF.
- DIV with A=0xFFF9 (-7), B=2 -> alu_out=0xFFFD, hi_out=0xFFFF. DIV with B=0 and A=0x0010 -> alu_out=0xFFFF, hi_out=0x0010, div_zero_out=1.
- BLT with A=0xFFFF, B=0x0001, add_in=0x0040 -> br_taken_out=1 and br_target_out=0x0040; with EX_MULDIV_EN undefined, MUL yields 0 and no stall.
